// File: rtl/md_rx_pipeline.sv
// md_rx_pipeline: elastic register pipeline for market data words with
// per-word sequence-gap tagging and delivery / gap counters.
// Optional feature macro: MD_SEQ_CHECK_EN (sequence check, seq_gap, gap_count).
// Without the macro, seq_gap and gap_count are tied to zero.
module md_rx_pipeline #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned STAGES = 2,
   parameter int unsigned SEQ_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] raw_market_data,
   input  logic              raw_valid,
   output logic              raw_ready,
   output logic [DATA_W-1:0] parsed_data,
   output logic              parsed_valid,
   input  logic              parsed_ready,
   output logic              seq_gap,
   output logic [15:0]       gap_count,
   output logic [31:0]       msg_count
);

   if (STAGES < 1 || STAGES > 8 || SEQ_W < 1 || SEQ_W > DATA_W) begin : g_bad_param
      $error("md_rx_pipeline: illegal STAGES or SEQ_W");
   end

   logic [DATA_W-1:0] st_data  [STAGES];
   logic [STAGES-1:0] st_valid;
   logic [DATA_W-1:0] src_data [STAGES];
   logic [STAGES-1:0] src_valid;
   logic [STAGES-1:0] adv;
   logic              all_full;

   // Stage k advances unless it and every stage after it are full while the
   // consumer stalls; written per stage to avoid a chained combinational loop.
   always_comb begin
      adv      = '0;
      all_full = 1'b1;
      for (int unsigned k = 0; k < STAGES; k++) begin
         all_full = 1'b1;
         for (int unsigned j = 0; j < STAGES; j++) begin
            if (j >= k) all_full = all_full & st_valid[j];
         end
         adv[k] = !all_full || parsed_ready;
      end
   end

   assign raw_ready = adv[0];

   // Load source for each stage: the input for stage 0, the previous stage otherwise.
   always_comb begin
      src_valid[0] = raw_valid;
      src_data[0]  = raw_market_data;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src_valid[k] = st_valid[k-1];
         src_data[k]  = st_data[k-1];
      end
   end

   // Stage registers: a stage loads whenever it is allowed to advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_valid <= '0;
         for (int unsigned k = 0; k < STAGES; k++) st_data[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               st_valid[k] <= src_valid[k];
               st_data[k]  <= src_data[k];
            end
         end
      end
   end

   assign parsed_valid = st_valid[STAGES-1];
   assign parsed_data  = st_data[STAGES-1];

   // Delivered-word counter, free-running wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) msg_count <= '0;
      else if (parsed_valid && parsed_ready) msg_count <= msg_count + 32'd1;
   end

`ifdef MD_SEQ_CHECK_EN
   logic [SEQ_W-1:0]  seq;
   logic [SEQ_W-1:0]  exp_seq;
   logic              armed;
   logic              in_gap;
   logic              accept;
   logic [STAGES-1:0] st_gap;
   logic [STAGES-1:0] src_gap;

   assign seq    = raw_market_data[SEQ_W-1:0];
   assign accept = raw_valid && raw_ready;
   assign in_gap = !armed && (seq != exp_seq);

   // Gap flag source per stage, following the data path.
   always_comb begin
      src_gap[0] = in_gap;
      for (int unsigned k = 1; k < STAGES; k++) src_gap[k] = st_gap[k-1];
   end

   // Gap flags ride alongside each stage's data word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_gap <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (adv[k]) st_gap[k] <= src_gap[k];
         end
      end
   end

   // Sequence tracker: first word after reset sets the baseline; every accepted
   // word re-seeds the expected value and flagged words bump the saturating count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed     <= 1'b1;
         exp_seq   <= '0;
         gap_count <= '0;
      end else if (accept) begin
         armed   <= 1'b0;
         exp_seq <= seq + SEQ_W'(1);
         if (in_gap && gap_count != 16'hFFFF) gap_count <= gap_count + 16'd1;
      end
   end

   assign seq_gap = st_gap[STAGES-1];
`else
   assign seq_gap   = 1'b0;
   assign gap_count = '0;
`endif

endmodule

// File: tb/tb_md_rx_pipeline.sv
// Testbench for md_rx_pipeline: table-driven directed vectors, hand-written
// stall and async-reset sequences, and randomized traffic checked against a
// queue-based reference model. Follows MD_SEQ_CHECK_EN for gap expectations.
module tb_md_rx_pipeline;

   localparam int unsigned DW = 64;
   localparam int unsigned ST = 2;
   localparam int unsigned SW = 16;
`ifdef MD_SEQ_CHECK_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] raw_market_data;
   logic          raw_valid;
   logic          raw_ready;
   logic [DW-1:0] parsed_data;
   logic          parsed_valid;
   logic          parsed_ready;
   logic          seq_gap;
   logic [15:0]   gap_count;
   logic [31:0]   msg_count;

   md_rx_pipeline #(.DATA_W(DW), .STAGES(ST), .SEQ_W(SW)) dut (
      .clk             (clk),
      .reset           (reset),
      .raw_market_data (raw_market_data),
      .raw_valid       (raw_valid),
      .raw_ready       (raw_ready),
      .parsed_data     (parsed_data),
      .parsed_valid    (parsed_valid),
      .parsed_ready    (parsed_ready),
      .seq_gap         (seq_gap),
      .gap_count       (gap_count),
      .msg_count       (msg_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: words in flight are a FIFO; gap rule from the sequence definition.
   typedef struct {
      logic [63:0] d;
      logic        g;
   } item_t;

   item_t       q[$];
   bit          armed_m;
   logic [15:0] exp_m;
   logic [31:0] msg_m;
   logic [15:0] gc_m;

   task automatic model_reset();
      q.delete();
      armed_m = 1'b1;
      exp_m   = '0;
      msg_m   = '0;
      gc_m    = '0;
   endtask

   function automatic logic [63:0] D(input logic [15:0] s);
      return {32'hC0FF_EE00, ~s, s};
   endfunction

   // One clock cycle: drive at negedge, check pre-edge state, update model for the coming edge.
   task automatic cycle(input logic v, input logic [63:0] d, input logic pr, output logic acc);
      item_t it;
      logic  g;
      @(negedge clk);
      raw_valid       = v;
      raw_market_data = d;
      parsed_ready    = pr;
      #1;
      chk("raw_ready", raw_ready, (q.size() < ST) || pr);
      chk("msg_count", msg_count, msg_m);
      chk("gap_count", gap_count, SEQ_EN ? gc_m : 16'h0);
      if (q.size() == 0) chk("parsed_valid_when_empty", parsed_valid, 1'b0);
      if (parsed_valid && pr && q.size() > 0) begin
         it = q.pop_front();
         chk("out_data", parsed_data, it.d);
         chk("out_gap", seq_gap, SEQ_EN ? it.g : 1'b0);
         msg_m++;
      end
      acc = v && raw_ready;
      if (acc) begin
         g       = armed_m ? 1'b0 : (d[15:0] != exp_m);
         armed_m = 1'b0;
         exp_m   = d[15:0] + 16'd1;
         if (g && gc_m != 16'hFFFF) gc_m++;
         it.d = d;
         it.g = g;
         q.push_back(it);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      raw_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit          rst;
      logic        v;
      logic [63:0] d;
      logic        exp_pv;
      logic [63:0] exp_pd;
      logic        exp_g;
      logic [31:0] exp_msg;
      logic [15:0] exp_gc;
   } vec_t;

   function automatic vec_t mk(bit rst, bit v, logic [15:0] s, bit pv, logic [15:0] ps,
                               bit g, int unsigned msg, int unsigned gc);
      vec_t r;
      r.rst     = rst;
      r.v       = v;
      r.d       = D(s);
      r.exp_pv  = pv;
      r.exp_pd  = D(ps);
      r.exp_g   = g & SEQ_EN;
      r.exp_msg = msg;
      r.exp_gc  = SEQ_EN ? 16'(gc) : 16'h0;
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vt[18];
      logic        acc;
      int          idx;
      logic [15:0] nxt;
      logic [15:0] s;
      logic [63:0] d;

      // consecutive 5,6,7 with two-cycle latency
      vt[0]  = mk(1, 1, 16'd5,  0, 16'd0,  0, 0, 0);
      vt[1]  = mk(0, 1, 16'd6,  0, 16'd0,  0, 0, 0);
      vt[2]  = mk(0, 1, 16'd7,  1, 16'd5,  0, 0, 0);
      vt[3]  = mk(0, 0, 16'd0,  1, 16'd6,  0, 1, 0);
      vt[4]  = mk(0, 0, 16'd0,  1, 16'd7,  0, 2, 0);
      vt[5]  = mk(0, 0, 16'd0,  0, 16'd0,  0, 3, 0);
      // 10, 12 (gap), 13
      vt[6]  = mk(1, 1, 16'd10, 0, 16'd0,  0, 0, 0);
      vt[7]  = mk(0, 1, 16'd12, 0, 16'd0,  0, 0, 0);
      vt[8]  = mk(0, 1, 16'd13, 1, 16'd10, 0, 0, 1);
      vt[9]  = mk(0, 0, 16'd0,  1, 16'd12, 1, 1, 1);
      vt[10] = mk(0, 0, 16'd0,  1, 16'd13, 0, 2, 1);
      vt[11] = mk(0, 0, 16'd0,  0, 16'd0,  0, 3, 1);
      // wrap FFFF -> 0 is clean, then 3 is a gap
      vt[12] = mk(1, 1, 16'hFFFF, 0, 16'd0, 0, 0, 0);
      vt[13] = mk(0, 1, 16'd0,  0, 16'd0,  0, 0, 0);
      vt[14] = mk(0, 1, 16'd3,  1, 16'hFFFF, 0, 0, 0);
      vt[15] = mk(0, 0, 16'd0,  1, 16'd0,  0, 1, 1);
      vt[16] = mk(0, 0, 16'd0,  1, 16'd3,  1, 2, 1);
      vt[17] = mk(0, 0, 16'd0,  0, 16'd0,  0, 3, 1);

      reset           = 1'b1;
      raw_valid       = 1'b0;
      raw_market_data = '0;
      parsed_ready    = 1'b1;
      #1;
      chk("rst_parsed_valid", parsed_valid, 1'b0);
      chk("rst_parsed_data", parsed_data, 64'h0);
      chk("rst_seq_gap", seq_gap, 1'b0);
      chk("rst_gap_count", gap_count, 16'h0);
      chk("rst_msg_count", msg_count, 32'h0);
      chk("rst_raw_ready", raw_ready, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 18; i++) begin
         if (vt[i].rst) do_reset();
         cycle(vt[i].v, vt[i].d, 1'b1, acc);
         chk("tbl_parsed_valid", parsed_valid, vt[i].exp_pv);
         if (vt[i].exp_pv) begin
            chk("tbl_parsed_data", parsed_data, vt[i].exp_pd);
            chk("tbl_seq_gap", seq_gap, vt[i].exp_g);
         end
         chk("tbl_msg_count", msg_count, vt[i].exp_msg);
         chk("tbl_gap_count", gap_count, vt[i].exp_gc);
      end

      // Stalled burst of four: two fit, then backpressure, then full drain in order.
      do_reset();
      idx = 0;
      for (int c = 0; c < 40 && !(idx == 4 && q.size() == 0); c++) begin
         cycle(idx < 4, D(16'(idx + 1)), c >= 4, acc);
         if (c == 2) begin
            chk("stall_accepted", idx, 2);
            chk("stall_raw_ready", raw_ready, 1'b0);
         end
         if (acc) idx++;
      end
      chk("burst_all_accepted", idx, 4);
      chk("burst_drained", q.size(), 0);
      @(posedge clk);
      #1;
      chk("burst_msg_count", msg_count, 32'd4);

      // Async reset with two words in flight, then 99 is the new baseline.
      do_reset();
      cycle(1'b1, D(16'd20), 1'b0, acc);
      cycle(1'b1, D(16'd40), 1'b0, acc);
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
      chk("inflight_valid", parsed_valid, 1'b1);
      chk("inflight_raw_ready", raw_ready, 1'b0);
      reset = 1'b1;
      #1;
      chk("async_parsed_valid", parsed_valid, 1'b0);
      chk("async_parsed_data", parsed_data, 64'h0);
      chk("async_msg_count", msg_count, 32'h0);
      chk("async_gap_count", gap_count, 16'h0);
      chk("async_raw_ready", raw_ready, 1'b1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b1, D(16'd99), 1'b1, acc);
      cycle(1'b0, 64'h0, 1'b1, acc);
      cycle(1'b0, 64'h0, 1'b1, acc);
      chk("baseline99_valid", parsed_valid, 1'b1);
      chk("baseline99_data", parsed_data, D(16'd99));
      chk("baseline99_gap", seq_gap, 1'b0);

      // Randomized traffic against the model.
      do_reset();
      nxt = 16'($urandom);
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 9))
            0:       s = 16'($urandom);
            1:       s = 16'hFFFF;
            2:       s = nxt + 16'd2;
            default: s = nxt;
         endcase
         d = {$urandom, 16'($urandom), s};
         cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, acc);
         if (acc) nxt = s + 16'd1;
      end
      for (int c = 0; c < 20 && q.size() != 0; c++) cycle(1'b0, 64'h0, 1'b1, acc);
      chk("random_drained", q.size(), 0);
      @(posedge clk);
      #1;
      chk("random_msg_count", msg_count, msg_m);
      chk("random_gap_count", gap_count, SEQ_EN ? gc_m : 16'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
